// File: rtl/leaf_pkg.sv
// Shared leaf definitions: packet field placement, control port codes and
// the payload layout of config / credit-return packets.
package leaf_pkg;

  // Control packets arriving from the BFT are steered by their port field.
  localparam int CTRL_CFG    = 0;
  localparam int CTRL_CREDIT = 1;

  // Payload bit positions inside config and credit-return packets.
  localparam int CFG_IDX_LSB    = 0;
  localparam int CFG_IDX_W      = 4;
  localparam int CFG_LEAF_LSB   = 4;
  localparam int CREDIT_INC_LSB = 8;

  // Packet is {valid, leaf, port, addr, payload}, payload at bit 0.
  function automatic int addr_lsb(input int payload_bits);
    return payload_bits;
  endfunction

  function automatic int port_lsb(input int payload_bits, input int addr_bits);
    return payload_bits + addr_bits;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first request at or above the pointer,
// wrapping, and moves the pointer just past the winner.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int PTR_W = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] grant_idx,
  output logic             grant_vld
);

  logic [PTR_W-1:0] ptr;

  always_comb begin
    int cand;
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = 0;
    for (int off = 0; off < N; off++) begin
      cand = int'(ptr) + off;
      if (cand >= N) cand = cand - N;
      if (!grant_vld && req[cand]) begin
        grant_vld   = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = PTR_W'(cand);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (grant_vld) begin
      ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/leaf_out_packer.sv
// Leaf egress engine: one-word holding register per user output, credit and
// sequence tracking per port, round-robin selection of one packet per cycle.
module leaf_out_packer
  import leaf_pkg::*;
#(
  parameter int PACKET_BITS   = 49,
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_LEAF_BITS = 5,
  parameter int NUM_PORT_BITS = 4,
  parameter int NUM_ADDR_BITS = 7,
  parameter int NUM_OUT_PORTS = 2
) (
  input  logic                                    clk,
  input  logic                                    reset_n,
  input  logic [PACKET_BITS-1:0]                  din_leaf_bft2interface,
  output logic [PACKET_BITS-1:0]                  dout_leaf_interface2bft,
  input  logic                                    resend,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   din_leaf_user2interface,
  input  logic [NUM_OUT_PORTS-1:0]                vld_user2interface,
  output logic [NUM_OUT_PORTS-1:0]                ack_interface2user,
  output logic                                    credit_err
);

  localparam int PTR_W    = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
  localparam int CRED_W   = NUM_ADDR_BITS + 1;
  localparam int PORT_LSB = port_lsb(PAYLOAD_BITS, NUM_ADDR_BITS);
  localparam logic [CRED_W-1:0] CRED_FULL = {1'b1, {NUM_ADDR_BITS{1'b0}}};

  logic                     in_vld, cfg_hit, cred_hit;
  logic [NUM_PORT_BITS-1:0] in_port;
  logic [CFG_IDX_W-1:0]     in_idx;
  logic [NUM_LEAF_BITS-1:0] cfg_leaf;
  logic [NUM_PORT_BITS-1:0] cfg_port;
  logic [CRED_W-1:0]        cred_inc;
  logic                     unused_ctrl;

  assign in_vld   = din_leaf_bft2interface[PACKET_BITS-1];
  assign in_port  = din_leaf_bft2interface[PORT_LSB +: NUM_PORT_BITS];
  assign in_idx   = din_leaf_bft2interface[CFG_IDX_LSB +: CFG_IDX_W];
  assign cfg_leaf = din_leaf_bft2interface[CFG_LEAF_LSB +: NUM_LEAF_BITS];
  assign cfg_port = din_leaf_bft2interface[CFG_LEAF_LSB+NUM_LEAF_BITS +: NUM_PORT_BITS];
  assign cred_inc = din_leaf_bft2interface[CREDIT_INC_LSB +: CRED_W];
  assign cfg_hit  = in_vld && (in_port == NUM_PORT_BITS'(CTRL_CFG));
  assign cred_hit = in_vld && (in_port == NUM_PORT_BITS'(CTRL_CREDIT));
  assign unused_ctrl = ^din_leaf_bft2interface;

  logic [PAYLOAD_BITS-1:0]  hold      [NUM_OUT_PORTS];
  logic [NUM_LEAF_BITS-1:0] dest_leaf [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0] dest_port [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] seq       [NUM_OUT_PORTS];
  logic [NUM_OUT_PORTS-1:0] eligible, grant, ovf;
  logic [PTR_W-1:0]         grant_idx;
  logic                     grant_vld;
  logic [PACKET_BITS-1:0]   dout_q;

  for (genvar i = 0; i < NUM_OUT_PORTS; i++) begin : g_port
    logic [PAYLOAD_BITS-1:0]  hold_q;
    logic                     full_q, cfg_q, hit;
    logic [NUM_LEAF_BITS-1:0] leaf_q;
    logic [NUM_PORT_BITS-1:0] port_q;
    logic [NUM_ADDR_BITS-1:0] seq_q;
    logic [CRED_W-1:0]        cred_q;
    logic [CRED_W:0]          cred_sum;

    // Out-of-range indices never match any port, so they fall away here.
    assign hit = (int'(in_idx) == i);
    // A word granted this cycle frees the register, so a refill can ride along.
    assign ack_interface2user[i] = reset_n & vld_user2interface[i] & (~full_q | grant[i]);

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        hold_q <= '0;
        full_q <= 1'b0;
      end else if (ack_interface2user[i]) begin
        hold_q <= din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS];
        full_q <= 1'b1;
      end else if (grant[i]) begin
        full_q <= 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        cfg_q  <= 1'b0;
        leaf_q <= '0;
        port_q <= '0;
      end else if (cfg_hit && hit) begin
        cfg_q  <= 1'b1;
        leaf_q <= cfg_leaf;
        port_q <= cfg_port;
      end
    end

    always_ff @(posedge clk) begin
      if (!reset_n)      seq_q <= '0;
      else if (grant[i]) seq_q <= seq_q + 1'b1;
    end

    // Grants need a nonzero credit, so the decrement never underflows.
    assign cred_sum = {1'b0, cred_q} - {{CRED_W{1'b0}}, grant[i]}
                    + ((cred_hit && hit) ? {1'b0, cred_inc} : '0);
    assign ovf[i]   = cred_sum > {1'b0, CRED_FULL};

    always_ff @(posedge clk) begin
      if (!reset_n)    cred_q <= CRED_FULL;
      else if (ovf[i]) cred_q <= CRED_FULL;
      else             cred_q <= cred_sum[CRED_W-1:0];
    end

    assign eligible[i]  = full_q & cfg_q & (cred_q != '0) & ~resend;
    assign hold[i]      = hold_q;
    assign dest_leaf[i] = leaf_q;
    assign dest_port[i] = port_q;
    assign seq[i]       = seq_q;
  end

  rr_arbiter #(
    .N     (NUM_OUT_PORTS),
    .PTR_W (PTR_W)
  ) u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (eligible),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  // Resend freezes the egress register rather than clearing it, so the packet
  // hidden while resend is high is presented again once it drops.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dout_q <= '0;
    end else if (!resend) begin
      if (grant_vld) dout_q <= {1'b1, dest_leaf[grant_idx], dest_port[grant_idx],
                                seq[grant_idx], hold[grant_idx]};
      else           dout_q <= '0;
    end
  end

  assign dout_leaf_interface2bft = resend ? '0 : dout_q;

  always_ff @(posedge clk) begin
    if (!reset_n)  credit_err <= 1'b0;
    else if (|ovf) credit_err <= 1'b1;
  end

endmodule

// File: doc/leaf_out_packer.md
# leaf_out_packer

Parametrised leaf-side output engine that takes NUM_OUT_PORTS user output streams (32-bit vld/ack), arbitrates them round-robin, and emits one addressed BFT packet per cycle with per-port credit flow control and per-port sequence numbering. It sits between the user kernel outputs and the BFT egress of a leaf. It generalises the fixed two-output leaf shell to any output count, and adds runtime destination configuration and credit return from the network.

## Interface
Parameters:
- PACKET_BITS, 49, total packet width; equals 1+NUM_LEAF_BITS+NUM_PORT_BITS+NUM_ADDR_BITS+PAYLOAD_BITS
- PAYLOAD_BITS, 32, user word width
- NUM_LEAF_BITS, 5, destination leaf field width
- NUM_PORT_BITS, 4, destination port field width
- NUM_ADDR_BITS, 7, sequence/credit field width; credit window = 2^NUM_ADDR_BITS
- NUM_OUT_PORTS, 2, user output ports, 1..8

Ports:
- clk  in  1  single clock
- reset_n  in  1  synchronous, active-low reset
- din_leaf_bft2interface  in  PACKET_BITS  control packets from BFT (config, credit return)
- dout_leaf_interface2bft  out  PACKET_BITS  registered egress packet; 0 when idle
- resend  in  1  freeze egress
- din_leaf_user2interface  in  NUM_OUT_PORTS*PAYLOAD_BITS  user words, port i at slice i
- vld_user2interface  in  NUM_OUT_PORTS  user valid
- ack_interface2user  out  NUM_OUT_PORTS  word accepted this cycle
- credit_err  out  1  sticky: credit return overflowed the window

## Operation
- Packet layout, MSB first: valid, leaf, port, addr, payload.
- Ingress control, only when the valid bit is set:
  - port field 0 = config packet. payload[3:0] selects output index k. payload[4+:NUM_LEAF_BITS] sets dest_leaf[k]. The next NUM_PORT_BITS set dest_port[k]. Sets cfg_ok[k].
  - port field 1 = credit return. payload[3:0] selects k. payload[8+:NUM_ADDR_BITS+1] is the increment.
  - Any other port field, or an index ≥ NUM_OUT_PORTS, is ignored.
- Per port holding register (1 word):
  - ack_i = vld_i & (~hold_full_i | grant_i) & ~resend_or_stalled, combinational.
  - An acked word is loaded into the holding register at the clock edge.
- Eligibility: port i is eligible when hold_full_i & cfg_ok_i & credit_i≠0 & ~resend.
- Arbiter: round-robin starting at rr_ptr.
  - Grant the first eligible port at or above rr_ptr, wrapping.
  - On grant, rr_ptr ← grant+1 mod NUM_OUT_PORTS. No grant leaves rr_ptr unchanged.
- Egress on grant g: dout ← {1, dest_leaf[g], dest_port[g], seq[g], hold[g]}. Then seq[g]++ (wraps mod 2^NUM_ADDR_BITS) and credit[g]--. With no grant, dout ← 0.
- Credits: width NUM_ADDR_BITS+1, each counter holding 0..2^NUM_ADDR_BITS.
  - Same-cycle send and return on one port: credit ← credit − 1 + inc.
  - If the result exceeds 2^NUM_ADDR_BITS, saturate at 2^NUM_ADDR_BITS and set credit_err.
- Resend:
  - While resend=1, dout is forced to 0 combinationally and no grants occur.
  - ack is issued only into empty holding registers.
  - Config and credit packets are still processed.
- Reset (reset_n=0 at an edge):
  - Holding registers empty; cfg_ok, dest, seq, rr_ptr cleared; credits = 2^NUM_ADDR_BITS.
  - dout = 0, credit_err = 0, ack = 0.
  - Reset mid-stream drops held words without emitting them.

## Timing
- User word acked at edge t, held from t+1, earliest egress on dout at t+2 (2-cycle latency).
- Sustained rate: one packet per cycle total. A single eligible port can sustain one word per cycle (hold refilled on grant cycle).
- A config packet on din at edge t affects eligibility from t+1.
- A credit return at edge t makes a zero-credit port eligible at t+1; its packet appears at t+2.
- credit_err is set at the edge of the overflowing update and cleared only by reset.

## Structure
- Shared package leaf_pkg: packet field offsets/widths, control port codes (CFG=0, CREDIT=1), and the config/credit payload bit positions. The existing leaf interface will reuse the same package.
- One natural sub-module: rr_arbiter (NUM_OUT_PORTS request in, one-hot grant plus index out, pointer register inside).
- Holding registers, credit counters and sequence counters are generate loops over NUM_OUT_PORTS.

## Test plan
- Reset, then configure port 0 → leaf 3/port 2; send 0xDEADBEEF on port 0 → dout = {1,3,2,0,0xDEADBEEF} exactly two cycles after ack; next word carries addr 1.
- NUM_OUT_PORTS=4, all configured, all vld held high for 12 cycles → grants rotate 0,1,2,3,0,…; one packet per cycle; no port starved.
- Port 1 sends 128 words with no credit return → packet 128 is emitted, then the port stalls (ack low once holding is full). Credit return inc=5 → exactly 5 more packets; seq wraps 127→0.
- Unconfigured port with vld=1 → one ack only, never emitted. Config arrives → emitted within 2 cycles.
- resend=1 for 10 cycles with traffic pending → dout=0 throughout. Egress resumes in RR order with no seq gaps.
- Credit return inc=3 on a full-credit port → credit stays 128, credit_err=1 until reset_n=0; reset mid-traffic → dout=0 next cycle, seq restarts at 0.
